// File: rtl/stopwatch_lap_bcd_if.sv
// Lap FIFO read port of stopwatch_lap_bcd.
// Handshake: the head entry transfers on every falling edge where lap_valid && lap_ready; lap_bcd holds while lap_valid && !lap_ready.
interface stopwatch_lap_bcd_if #(
  parameter int LAP_DEPTH = 8
);
  localparam int CW = $clog2(LAP_DEPTH) + 1;

  logic          lap_valid;
  logic          lap_ready;
  logic [35:0]   lap_bcd;
  logic [CW-1:0] lap_count;
  logic          lap_drop;

  modport master (output lap_valid, lap_bcd, lap_count, lap_drop, input lap_ready);
  modport slave  (input lap_valid, lap_bcd, lap_count, lap_drop, output lap_ready);
endinterface

// File: rtl/stopwatch_lap_bcd.sv
// Run/stop/clear stopwatch counting HH:MM:SS.mmm as a cascaded BCD chain,
// with a millisecond prescaler and a lap-capture FIFO. All state moves on the falling edge.
module stopwatch_lap_bcd #(
  parameter int CLK_PER_MS = 50000,
  parameter int LAP_DEPTH  = 8,
  parameter int SATURATE   = 1
) (
  input  logic        NEclk,
  input  logic        Nreset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [35:0] time_bcd,
  output logic        running,
  output logic        ovf,
  output logic [1:0]  state_dbg,
  stopwatch_lap_bcd_if.master lap_if
);
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  // Per-digit upper limits; also the saturation value 99:59:59.999.
  localparam logic [35:0] MAX_TIME = 36'h995959999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   presc_q;
  logic [35:0]     time_q;
  logic [35:0]     time_inc;
  logic            carry;
  logic            tick;
  logic            running_q;
  logic            ovf_q;

  assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  // carry is left set only when every digit rolled over, i.e. the chain overflowed.
  always_comb begin
    time_inc = time_q;
    carry    = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (carry) begin
        if (time_q[4*i +: 4] >= MAX_TIME[4*i +: 4]) begin
          time_inc[4*i +: 4] = 4'd0;
        end else begin
          time_inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      time_q    <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      time_q    <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (tick) begin
        presc_q <= '0;
        if (!carry) begin
          time_q <= time_inc;
        end else begin
          ovf_q <= 1'b1;
          if (SATURATE == 0) time_q <= '0;
        end
      end else if (state_q == RUN) begin
        presc_q <= presc_q + PW'(1);
      end

      if (start_stop) begin
        case (state_q)
          IDLE, PAUSE: begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          RUN: begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign time_bcd  = time_q;
  assign running   = running_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

  logic [35:0]   mem [LAP_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          drop_q;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;

  assign full     = (count_q == CW'(LAP_DEPTH));
  assign pop      = (count_q != '0) && lap_if.lap_ready;
  assign push_req = lap && !clear;
  // A pop on the same edge frees the slot, so a full FIFO still takes the push.
  assign push_ok  = push_req && (!full || pop);

  always_ff @(negedge NEclk) begin
    if (push_ok) mem[wr_ptr] <= time_q;
  end

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && !push_ok) drop_q <= 1'b1;
    end
  end

  assign lap_if.lap_valid = (count_q != '0);
  assign lap_if.lap_bcd   = (count_q != '0) ? mem[rd_ptr] : '0;
  assign lap_if.lap_count = count_q;
  assign lap_if.lap_drop  = drop_q;
endmodule

// File: tb/tb_stopwatch_lap_bcd.sv
// Directed bench for stopwatch_lap_bcd: a saturating instance (4 clk/ms, 4 laps)
// and a wrapping instance (1 clk/ms, 2 laps).
module tb_stopwatch_lap_bcd;
  logic        NEclk = 1'b0;
  logic        Nreset;
  logic        start_stop, clear, lap;
  logic [35:0] time_bcd;
  logic        running, ovf;
  logic [1:0]  state_dbg;

  logic        start_stop2, clear2, lap2;
  logic [35:0] time_bcd2;
  logic        running2, ovf2;
  logic [1:0]  state_dbg2;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [35:0] exp_q[$];

  stopwatch_lap_bcd_if #(.LAP_DEPTH(4)) lif ();
  stopwatch_lap_bcd_if #(.LAP_DEPTH(2)) lif2 ();

  stopwatch_lap_bcd #(.CLK_PER_MS(4), .LAP_DEPTH(4), .SATURATE(1)) dut (
    .NEclk(NEclk), .Nreset(Nreset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .time_bcd(time_bcd), .running(running), .ovf(ovf), .state_dbg(state_dbg), .lap_if(lif)
  );

  stopwatch_lap_bcd #(.CLK_PER_MS(1), .LAP_DEPTH(2), .SATURATE(0)) dut2 (
    .NEclk(NEclk), .Nreset(Nreset), .start_stop(start_stop2), .clear(clear2), .lap(lap2),
    .time_bcd(time_bcd2), .running(running2), .ovf(ovf2), .state_dbg(state_dbg2), .lap_if(lif2)
  );

  // Clock/reset: falling edge is active; the bench drives and samples on the rising edge.
  always #5 NEclk = ~NEclk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge NEclk);
  endtask

  task automatic pulse_start();
    start_stop = 1'b1; @(posedge NEclk); start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; @(posedge NEclk); lap = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; @(posedge NEclk); clear = 1'b0;
  endtask

  task automatic test_reset();
    Nreset = 1'b0; start_stop = 0; clear = 0; lap = 0; lif.lap_ready = 0;
    start_stop2 = 0; clear2 = 0; lap2 = 0; lif2.lap_ready = 0;
    wait_cyc(3);
    tests_run++; if (time_bcd !== 36'h0) begin tests_failed++; $display("FAIL reset_time: got %h want %h", time_bcd, 36'h0); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL reset_running: got %b want 0", running); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    tests_run++; if (lif.lap_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_lap_valid: got %b want 0", lif.lap_valid); end
    tests_run++; if (lif.lap_count !== 3'd0) begin tests_failed++; $display("FAIL reset_lap_count: got %0d want 0", lif.lap_count); end
    tests_run++; if (lif.lap_drop !== 1'b0) begin tests_failed++; $display("FAIL reset_lap_drop: got %b want 0", lif.lap_drop); end
    tests_run++; if (lif.lap_bcd !== 36'h0) begin tests_failed++; $display("FAIL reset_lap_bcd: got %h want %h", lif.lap_bcd, 36'h0); end
    tests_run++; if (time_bcd2 !== 36'h0) begin tests_failed++; $display("FAIL reset_time2: got %h want %h", time_bcd2, 36'h0); end
    Nreset = 1'b1;
    wait_cyc(2);
    tests_run++; if (time_bcd !== 36'h0) begin tests_failed++; $display("FAIL idle_time: got %h want %h", time_bcd, 36'h0); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL idle_running: got %b want 0", running); end
  endtask

  task automatic test_count();
    do_clear();
    pulse_start();
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL count_running: got %b want 1", running); end
    tests_run++; if (state_dbg !== 2'd1) begin tests_failed++; $display("FAIL count_state_run: got %0d want 1", state_dbg); end
    wait_cyc(3);
    tests_run++; if (time_bcd !== 36'h0) begin tests_failed++; $display("FAIL count_before_tick: got %h want %h", time_bcd, 36'h0); end
    wait_cyc(1);
    tests_run++; if (time_bcd !== 36'h1) begin tests_failed++; $display("FAIL count_first_tick: got %h want %h", time_bcd, 36'h1); end
    wait_cyc(3996);
    tests_run++; if (time_bcd !== 36'h000001000) begin tests_failed++; $display("FAIL count_one_second: got %h want %h", time_bcd, 36'h000001000); end
  endtask

  task automatic test_pause();
    do_clear();
    pulse_start();
    wait_cyc(6);
    tests_run++; if (time_bcd !== 36'h1) begin tests_failed++; $display("FAIL pause_pre: got %h want %h", time_bcd, 36'h1); end
    pulse_start();
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL pause_running: got %b want 0", running); end
    tests_run++; if (state_dbg !== 2'd2) begin tests_failed++; $display("FAIL pause_state: got %0d want 2", state_dbg); end
    wait_cyc(20);
    tests_run++; if (time_bcd !== 36'h1) begin tests_failed++; $display("FAIL pause_frozen: got %h want %h", time_bcd, 36'h1); end
    pulse_start();
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL resume_running: got %b want 1", running); end
    tests_run++; if (time_bcd !== 36'h1) begin tests_failed++; $display("FAIL resume_edge_time: got %h want %h", time_bcd, 36'h1); end
    wait_cyc(1);
    tests_run++; if (time_bcd !== 36'h2) begin tests_failed++; $display("FAIL resume_phase: got %h want %h", time_bcd, 36'h2); end
  endtask

  task automatic test_cascade();
    do_clear();
    pulse_start();
    force dut.time_q = 36'h005959999;
    #1 release dut.time_q;
    wait_cyc(3);
    tests_run++; if (time_bcd !== 36'h005959999) begin tests_failed++; $display("FAIL cascade_preload: got %h want %h", time_bcd, 36'h005959999); end
    wait_cyc(1);
    tests_run++; if (time_bcd !== 36'h010000000) begin tests_failed++; $display("FAIL cascade_hour: got %h want %h", time_bcd, 36'h010000000); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL cascade_ovf: got %b want 0", ovf); end
    force dut.time_q = 36'h995959999;
    #1 release dut.time_q;
    wait_cyc(3);
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL sat_ovf_early: got %b want 0", ovf); end
    wait_cyc(1);
    tests_run++; if (time_bcd !== 36'h995959999) begin tests_failed++; $display("FAIL sat_hold: got %h want %h", time_bcd, 36'h995959999); end
    tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL sat_ovf: got %b want 1", ovf); end
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL sat_running: got %b want 1", running); end
    wait_cyc(8);
    tests_run++; if (time_bcd !== 36'h995959999) begin tests_failed++; $display("FAIL sat_hold_later: got %h want %h", time_bcd, 36'h995959999); end
    tests_run++; if (state_dbg !== 2'd1) begin tests_failed++; $display("FAIL sat_state: got %0d want 1", state_dbg); end
  endtask

  task automatic test_wrap();
    start_stop2 = 1'b1; @(posedge NEclk); start_stop2 = 1'b0;
    tests_run++; if (running2 !== 1'b1) begin tests_failed++; $display("FAIL wrap_running: got %b want 1", running2); end
    force dut2.time_q = 36'h995959999;
    #1 release dut2.time_q;
    wait_cyc(1);
    tests_run++; if (time_bcd2 !== 36'h0) begin tests_failed++; $display("FAIL wrap_zero: got %h want %h", time_bcd2, 36'h0); end
    tests_run++; if (ovf2 !== 1'b1) begin tests_failed++; $display("FAIL wrap_ovf: got %b want 1", ovf2); end
    wait_cyc(1);
    tests_run++; if (time_bcd2 !== 36'h1) begin tests_failed++; $display("FAIL wrap_continue: got %h want %h", time_bcd2, 36'h1); end
  endtask

  task automatic test_clear_priority();
    for (int i = 0; i < 5; i++) pulse_lap();
    tests_run++; if (lif.lap_count !== 3'd4) begin tests_failed++; $display("FAIL clrpri_pre_count: got %0d want 4", lif.lap_count); end
    tests_run++; if (lif.lap_drop !== 1'b1) begin tests_failed++; $display("FAIL clrpri_pre_drop: got %b want 1", lif.lap_drop); end
    tests_run++; if (lif.lap_bcd !== 36'h995959999) begin tests_failed++; $display("FAIL clrpri_pre_head: got %h want %h", lif.lap_bcd, 36'h995959999); end
    clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
    @(posedge NEclk);
    clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
    tests_run++; if (time_bcd !== 36'h0) begin tests_failed++; $display("FAIL clrpri_time: got %h want %h", time_bcd, 36'h0); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL clrpri_running: got %b want 0", running); end
    tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL clrpri_state: got %0d want 0", state_dbg); end
    tests_run++; if (lif.lap_count !== 3'd0) begin tests_failed++; $display("FAIL clrpri_count: got %0d want 0", lif.lap_count); end
    tests_run++; if (lif.lap_valid !== 1'b0) begin tests_failed++; $display("FAIL clrpri_valid: got %b want 0", lif.lap_valid); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL clrpri_ovf: got %b want 0", ovf); end
    tests_run++; if (lif.lap_drop !== 1'b0) begin tests_failed++; $display("FAIL clrpri_drop: got %b want 0", lif.lap_drop); end
    wait_cyc(4);
    tests_run++; if (time_bcd !== 36'h0) begin tests_failed++; $display("FAIL clrpri_stays_idle: got %h want %h", time_bcd, 36'h0); end
  endtask

  task automatic test_lap_fifo();
    do_clear();
    pulse_start();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      wait_cyc(3);
      pulse_lap();
      exp_q.push_back(36'(k));
    end
    tests_run++; if (lif.lap_count !== 3'd4) begin tests_failed++; $display("FAIL fifo_full_count: got %0d want 4", lif.lap_count); end
    tests_run++; if (lif.lap_drop !== 1'b0) begin tests_failed++; $display("FAIL fifo_full_drop: got %b want 0", lif.lap_drop); end
    tests_run++; if (lif.lap_bcd !== 36'h0) begin tests_failed++; $display("FAIL fifo_full_head: got %h want %h", lif.lap_bcd, 36'h0); end
    wait_cyc(3);
    lap = 1'b1; lif.lap_ready = 1'b1;
    @(posedge NEclk);
    lap = 1'b0; lif.lap_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(36'h4);
    tests_run++; if (lif.lap_count !== 3'd4) begin tests_failed++; $display("FAIL pushpop_count: got %0d want 4", lif.lap_count); end
    tests_run++; if (lif.lap_drop !== 1'b0) begin tests_failed++; $display("FAIL pushpop_drop: got %b want 0", lif.lap_drop); end
    tests_run++; if (lif.lap_bcd !== 36'h1) begin tests_failed++; $display("FAIL pushpop_head: got %h want %h", lif.lap_bcd, 36'h1); end
    wait_cyc(3);
    pulse_lap();
    tests_run++; if (lif.lap_count !== 3'd4) begin tests_failed++; $display("FAIL drop_count: got %0d want 4", lif.lap_count); end
    tests_run++; if (lif.lap_drop !== 1'b1) begin tests_failed++; $display("FAIL drop_flag: got %b want 1", lif.lap_drop); end
    wait_cyc(3);
    tests_run++; if (lif.lap_bcd !== 36'h1) begin tests_failed++; $display("FAIL head_stable: got %h want %h", lif.lap_bcd, 36'h1); end
    lif.lap_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (lif.lap_bcd !== exp_q[i]) begin tests_failed++; $display("FAIL drain_%0d: got %h want %h", i, lif.lap_bcd, exp_q[i]); end
      @(posedge NEclk);
    end
    lif.lap_ready = 1'b0;
    tests_run++; if (lif.lap_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_valid: got %b want 0", lif.lap_valid); end
    tests_run++; if (lif.lap_count !== 3'd0) begin tests_failed++; $display("FAIL drain_count: got %0d want 0", lif.lap_count); end
  endtask

  task automatic test_lap_tick_edge();
    do_clear();
    pulse_start();
    wait_cyc(3);
    lap = 1'b1;
    #1;
    tests_run++; if (lif.lap_valid !== 1'b0) begin tests_failed++; $display("FAIL no_bypass: got %b want 0", lif.lap_valid); end
    @(posedge NEclk);
    lap = 1'b0;
    tests_run++; if (time_bcd !== 36'h1) begin tests_failed++; $display("FAIL tick_lap_time: got %h want %h", time_bcd, 36'h1); end
    tests_run++; if (lif.lap_valid !== 1'b1) begin tests_failed++; $display("FAIL tick_lap_valid: got %b want 1", lif.lap_valid); end
    tests_run++; if (lif.lap_bcd !== 36'h0) begin tests_failed++; $display("FAIL tick_lap_pre_inc: got %h want %h", lif.lap_bcd, 36'h0); end
    pulse_lap();
    pulse_start();
    tests_run++; if (lif.lap_count !== 3'd2) begin tests_failed++; $display("FAIL lap_survives_pause: got %0d want 2", lif.lap_count); end
    tests_run++; if (lif.lap_bcd !== 36'h0) begin tests_failed++; $display("FAIL lap_head_after_pause: got %h want %h", lif.lap_bcd, 36'h0); end
  endtask

  task automatic test_async_reset();
    do_clear();
    pulse_start();
    wait_cyc(10);
    pulse_lap();
    tests_run++; if (time_bcd !== 36'h2) begin tests_failed++; $display("FAIL areset_pre_time: got %h want %h", time_bcd, 36'h2); end
    #2 Nreset = 1'b0;
    #1;
    tests_run++; if (time_bcd !== 36'h0) begin tests_failed++; $display("FAIL areset_time: got %h want %h", time_bcd, 36'h0); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL areset_running: got %b want 0", running); end
    tests_run++; if (lif.lap_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid: got %b want 0", lif.lap_valid); end
    tests_run++; if (lif.lap_count !== 3'd0) begin tests_failed++; $display("FAIL areset_count: got %0d want 0", lif.lap_count); end
    tests_run++; if (lif.lap_bcd !== 36'h0) begin tests_failed++; $display("FAIL areset_lap_bcd: got %h want %h", lif.lap_bcd, 36'h0); end
    tests_run++; if (ovf2 !== 1'b0) begin tests_failed++; $display("FAIL areset_ovf2: got %b want 0", ovf2); end
    tests_run++; if (time_bcd2 !== 36'h0) begin tests_failed++; $display("FAIL areset_time2: got %h want %h", time_bcd2, 36'h0); end
    @(posedge NEclk);
    Nreset = 1'b1;
    wait_cyc(2);
    tests_run++; if (time_bcd !== 36'h0) begin tests_failed++; $display("FAIL post_reset_idle: got %h want %h", time_bcd, 36'h0); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_cascade();
    test_wrap();
    test_clear_priority();
    test_lap_fifo();
    test_lap_tick_edge();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
